// File: rtl/vadf_decoder.sv
// VADF receive decoder: Hamming-corrected location field and a two-stage
// valid/ready pipeline that rebuilds a 32-bit approximate value.
module vadf_decoder #(
    parameter logic [1:0] a = 2'd1,
    parameter logic [1:0] b = 2'd2,
    parameter logic [1:0] c = 2'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  mode_sel,
    input  logic [15:0] in_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        err_corrected,
    output logic        err_detected,
    output logic [15:0] cnt_corr,
    output logic [15:0] cnt_det
);
    localparam logic [1:0] F_BAD = 2'd0;
    localparam logic [1:0] F_16  = 2'd1;
    localparam logic [1:0] F_12  = 2'd2;
    localparam logic [1:0] F_8   = 2'd3;

    logic        en;
    logic        hs;
    logic        is16;
    logic        is12;
    logic        is8;

    logic [4:0]  hl;
    logic [3:0]  he;
    logic [2:0]  syn;
    logic [4:0]  hloc;
    logic        hcorr;

    logic        s1_valid_q, s1_valid_d;
    logic [1:0]  s1_fmt_q,   s1_fmt_d;
    logic [4:0]  s1_loc_q,   s1_loc_d;
    logic [5:0]  s1_dat_q,   s1_dat_d;
    logic        s1_zero_q,  s1_zero_d;
    logic        s1_corr_q,  s1_corr_d;
    logic        s1_det_q,   s1_det_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q,  out_data_d;
    logic        corr_q,      corr_d;
    logic        det_q,       det_d;
    logic [15:0] cnt_corr_q,  cnt_corr_d;
    logic [15:0] cnt_det_q,   cnt_det_d;

    logic [31:0] one_l;
    logic [31:0] mask;
    logic [31:0] dext;
    logic [31:0] recon;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;
    assign hs       = out_valid_q & out_ready;

    assign is16 = (mode_sel != 2'd0) && (mode_sel == a);
    assign is12 = (mode_sel != 2'd0) && (mode_sel == b) && !is16;
    assign is8  = (mode_sel != 2'd0) && (mode_sel == c) && !is16 && !is12;

    // Location field and check bits sit at different offsets in 16/12-bit codes.
    always_comb begin
        hl    = is16 ? in_code[14:10] : in_code[11:7];
        he    = is16 ? in_code[9:6]   : in_code[6:3];
        syn   = {he[3] ^ hl[4] ^ hl[2] ^ hl[1],
                 he[2] ^ hl[4] ^ hl[3] ^ hl[1],
                 he[1] ^ hl[4] ^ hl[3] ^ hl[2]};
        hloc  = hl;
        hcorr = 1'b0;
        case (syn)
            3'b111: begin hloc[4] = ~hl[4]; hcorr = 1'b1; end
            3'b011: begin hloc[3] = ~hl[3]; hcorr = 1'b1; end
            3'b101: begin hloc[2] = ~hl[2]; hcorr = 1'b1; end
            3'b110: begin hloc[1] = ~hl[1]; hcorr = 1'b1; end
            3'b100, 3'b010, 3'b001: hcorr = 1'b1;
            default: hcorr = 1'b0;
        endcase
    end

    always_comb begin
        s1_valid_d = in_valid;
        s1_fmt_d   = F_BAD;
        s1_loc_d   = '0;
        s1_dat_d   = '0;
        s1_zero_d  = 1'b0;
        s1_corr_d  = 1'b0;
        s1_det_d   = 1'b1;
        if (is16) begin
            s1_fmt_d  = F_16;
            s1_loc_d  = hloc;
            s1_dat_d  = in_code[5:0];
            s1_zero_d = (in_code == 16'd0);
            s1_corr_d = hcorr;
            s1_det_d  = (he[0] ^ hl[0]) | (in_code[15] ^ (^in_code[5:0]));
        end else if (is12) begin
            s1_fmt_d  = F_12;
            s1_loc_d  = hloc;
            s1_dat_d  = {3'd0, in_code[2:0]};
            s1_zero_d = (in_code[11:0] == 12'd0);
            s1_corr_d = hcorr;
            s1_det_d  = he[0] ^ hl[0];
        end else if (is8) begin
            s1_fmt_d  = F_8;
            s1_loc_d  = in_code[7:3];
            s1_dat_d  = {4'd0, in_code[1:0]};
            s1_zero_d = (in_code[7:0] == 8'd0);
            s1_det_d  = in_code[2] ^ (^in_code[7:3]);
        end
    end

    // Leading one at L, mantissa bits right below it, zero-filled tail.
    always_comb begin
        one_l = 32'd1 << s1_loc_q;
        mask  = one_l - 32'd1;
        dext  = {26'd0, s1_dat_q};
        case (s1_fmt_q)
            F_16: recon = (s1_loc_q < 5'd6)
                        ? (one_l | (dext & mask))
                        : (one_l | (dext << (s1_loc_q - 5'd6)));
            F_12: recon = (s1_loc_q < 5'd3)
                        ? (one_l | (dext & mask))
                        : (one_l | (dext << (s1_loc_q - 5'd3)));
            F_8:  recon = (s1_loc_q == 5'd1)
                        ? (32'd2 | {31'd0, s1_dat_q[0]})
                        : (one_l | (dext << (s1_loc_q - 5'd2)));
            default: recon = '0;
        endcase
    end

    always_comb begin
        out_valid_d = s1_valid_q;
        out_data_d  = recon;
        corr_d      = s1_corr_q;
        det_d       = s1_det_q;
        if (s1_fmt_q == F_BAD) begin
            out_data_d = '0;
            corr_d     = 1'b0;
            det_d      = 1'b1;
        end else if (s1_zero_q) begin
            out_data_d = '0;
            corr_d     = 1'b0;
            det_d      = 1'b0;
        end else if (s1_loc_q == 5'd0) begin
            out_data_d = '0;
            det_d      = 1'b1;
        end
    end

    always_comb begin
        cnt_corr_d = cnt_corr_q;
        cnt_det_d  = cnt_det_q;
        if (hs && corr_q && (cnt_corr_q != 16'hFFFF))
            cnt_corr_d = cnt_corr_q + 16'd1;
        if (hs && det_q && (cnt_det_q != 16'hFFFF))
            cnt_det_d = cnt_det_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= F_BAD;
            s1_loc_q    <= '0;
            s1_dat_q    <= '0;
            s1_zero_q   <= 1'b0;
            s1_corr_q   <= 1'b0;
            s1_det_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            corr_q      <= 1'b0;
            det_q       <= 1'b0;
            cnt_corr_q  <= '0;
            cnt_det_q   <= '0;
        end else begin
            if (en) begin
                s1_valid_q  <= s1_valid_d;
                s1_fmt_q    <= s1_fmt_d;
                s1_loc_q    <= s1_loc_d;
                s1_dat_q    <= s1_dat_d;
                s1_zero_q   <= s1_zero_d;
                s1_corr_q   <= s1_corr_d;
                s1_det_q    <= s1_det_d;
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
                corr_q      <= corr_d;
                det_q       <= det_d;
            end
            cnt_corr_q <= cnt_corr_d;
            cnt_det_q  <= cnt_det_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign err_corrected = corr_q;
    assign err_detected  = det_q;
    assign cnt_corr      = cnt_corr_q;
    assign cnt_det       = cnt_det_q;
endmodule

// File: tb/tb_vadf_decoder.sv
// Directed bench for vadf_decoder with an expected-result queue.
module tb_vadf_decoder;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode_sel;
    logic [15:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        err_corrected;
    logic        err_detected;
    logic [15:0] cnt_corr;
    logic [15:0] cnt_det;

    typedef struct packed {
        logic [31:0] data;
        logic        corr;
        logic        det;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   bulk = 0;

    vadf_decoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode_sel(mode_sel), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data),
        .err_corrected(err_corrected), .err_detected(err_detected),
        .cnt_corr(cnt_corr), .cnt_det(cnt_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [15:0] code,
                        input logic [31:0] d, input logic co, input logic de);
        int n = 0;
        mode_sel = m;
        in_code  = code;
        in_valid = 1'b1;
        sb.push_back(exp_t'{data: d, corr: co, det: de});
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (in_ready) else begin
            failures++;
            $error("FAIL accept_timeout observed=in_ready=0 expected=in_ready=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL drain observed=%0d pending expected=0 pending", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        mode_sel  = 2'd0;
        in_code   = 16'd0;
        out_ready = 1'b0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (!rst && !bulk && out_valid && out_ready) begin
                    checks++;
                    assert (sb.size() != 0) else begin
                        failures++;
                        $error("FAIL extra_beat observed=data %h expected=no beat", out_data);
                    end
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk32("out_data", out_data, e.data);
                        chk1("err_corrected", err_corrected, e.corr);
                        chk1("err_detected", err_detected, e.det);
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk32("rst_out_data", out_data, 32'd0);
        chk1("rst_corr", err_corrected, 1'b0);
        chk1("rst_det", err_detected, 1'b0);
        chk32("rst_cnt_corr", 32'(cnt_corr), 32'd0);
        chk32("rst_cnt_det", 32'(cnt_det), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        send(2'd1, 16'h9DDA, 32'd180, 1'b0, 1'b0);
        @(negedge clk);
        chk1("latency_c1", out_valid, 1'b0);
        @(negedge clk);
        chk1("latency_c2", out_valid, 1'b1);
        drain();

        send(2'd1, 16'hDDDA, 32'd180, 1'b1, 1'b0);
        send(2'd1, 16'h9D9A, 32'd180, 1'b0, 1'b1);
        send(2'd1, 16'h0F45, 32'd13, 1'b0, 1'b0);
        send(2'd1, 16'h0000, 32'd0, 1'b0, 1'b0);
        send(2'd2, 16'h0161, 32'd5, 1'b0, 1'b0);
        send(2'd2, 16'h0169, 32'd5, 1'b0, 1'b1);
        send(2'd2, 16'h0121, 32'd5, 1'b1, 1'b0);
        send(2'd3, 16'h00FC, 32'h8000_0000, 1'b0, 1'b0);
        send(2'd3, 16'h00F8, 32'h8000_0000, 1'b0, 1'b1);
        send(2'd3, 16'h0001, 32'd0, 1'b0, 1'b1);
        send(2'd0, 16'h9DDA, 32'd0, 1'b0, 1'b1);
        drain();
        chk32("cnt_corr_mix", 32'(cnt_corr), 32'd2);
        chk32("cnt_det_mix", 32'(cnt_det), 32'd5);

        fork
            begin
                send(2'd1, 16'h9DDA, 32'd180, 1'b0, 1'b0);
                send(2'd1, 16'h0F45, 32'd13, 1'b0, 1'b0);
                send(2'd2, 16'h0161, 32'd5, 1'b0, 1'b0);
                send(2'd3, 16'h00FC, 32'h8000_0000, 1'b0, 1'b0);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk1("stall_valid", out_valid, 1'b1);
                    chk1("stall_in_ready", in_ready, 1'b0);
                    chk32("stall_data", out_data,
                          (sb.size() != 0) ? sb[0].data : 32'hDEAD_BEEF);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk32("cnt_det_after_bp", 32'(cnt_det), 32'd5);

        out_ready = 1'b0;
        mode_sel  = 2'd1;
        in_code   = 16'h9DDA;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_code = 16'h0F45;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk1("inflight_valid", out_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk32("midrst_cnt_corr", 32'(cnt_corr), 32'd0);
        chk32("midrst_cnt_det", 32'(cnt_det), 32'd0);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk1("no_stale_beat", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        bulk      = 1'b1;
        mode_sel  = 2'd0;
        in_code   = 16'd0;
        in_valid  = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bulk = 1'b0;
        chk32("cnt_det_sat", 32'(cnt_det), 32'h0000_FFFF);
        chk32("cnt_corr_bulk", 32'(cnt_corr), 32'd0);
        chk1("bulk_idle", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
